// File: rtl/riscv_dmem_responder.sv
// Data-memory slave for the core's data port: byte-masked writes, one-cycle registered reads,
// post-reset clear sequencer, saturating access counters. Optional alignment check: DMEM_ALIGN_CHECK_EN.
module riscv_dmem_responder #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [31:0]      dmaddr_in,
   input  logic [31:0]      dmwdata_in,
   input  logic [3:0]       dmwr_mask_in,
   input  logic             dmwr_req_in,
   output logic [31:0]      dmrdata_out,
   output logic             busy_out,
   output logic             err_out,
   output logic [CNT_W-1:0] wr_cnt_out,
   output logic [CNT_W-1:0] rd_cnt_out
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == CNT_MAX) begin
         result = value;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lane_en);
      logic [31:0] merged;
      merged = old_word;
      for (int k = 0; k < 4; k++) begin
         if (lane_en[k]) begin
            merged[8*k +: 8] = new_word[8*k +: 8];
         end else begin
            merged[8*k +: 8] = old_word[8*k +: 8];
         end
      end
      return merged;
   endfunction

`ifdef DMEM_ALIGN_CHECK_EN
   function automatic logic [1:0] lowest_lane(input logic [3:0] lane_en);
      logic [1:0] lane;
      casez (lane_en)
         4'b???1: lane = 2'd0;
         4'b??10: lane = 2'd1;
         4'b?100: lane = 2'd2;
         default: lane = 2'd3;
      endcase
      return lane;
   endfunction

   function automatic logic lanes_contiguous(input logic [3:0] lane_en);
      logic ok;
      case (lane_en)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b0110, 4'b1100,
         4'b0111, 4'b1110, 4'b1111: ok = 1'b1;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction
`endif

   state_t           state_q, state_d;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

   logic [31:0]      mem_q [DEPTH];
   logic             mem_we;
   logic [IDX_W-1:0] mem_widx;
   logic [31:0]      mem_wdata;

   logic [IDX_W-1:0] acc_idx;
   logic             out_of_range;
   logic             misaligned;
   logic             reject;

   assign acc_idx      = dmaddr_in[IDX_W+1:2];
   assign out_of_range = |dmaddr_in[31:IDX_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
   // Writes must start at the addressed lane and cover contiguous lanes; reads must be word aligned.
   always_comb begin
      misaligned = 1'b0;
      if (dmwr_req_in) begin
         if (dmwr_mask_in != 4'b0000) begin
            misaligned = (lowest_lane(dmwr_mask_in) != dmaddr_in[1:0]) ||
                         !lanes_contiguous(dmwr_mask_in);
         end else begin
            misaligned = 1'b0;
         end
      end else begin
         misaligned = (dmaddr_in[1:0] != 2'b00);
      end
   end
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^dmaddr_in[1:0];
   assign misaligned      = 1'b0;
`endif

   assign reject = out_of_range | misaligned;

   // Next-state, output and memory-port decode for the clear sequencer and normal service.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      rdata_d   = 32'h0000_0000;
      err_d     = 1'b0;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      mem_we    = 1'b0;
      mem_widx  = acc_idx;
      mem_wdata = merge_bytes(mem_q[acc_idx], dmwdata_in, dmwr_mask_in);
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_widx  = clr_idx_q;
            mem_wdata = 32'h0000_0000;
            if (clr_idx_q == LAST_IDX) begin
               state_d   = ST_READY;
               clr_idx_d = IDX_ZERO;
            end else begin
               state_d   = ST_CLEAR;
               clr_idx_d = clr_idx_q + IDX_ONE;
            end
         end
         ST_READY: begin
            if (reject) begin
               err_d = 1'b1;
            end else if (dmwr_req_in) begin
               mem_we   = 1'b1;
               wr_cnt_d = sat_inc(wr_cnt_q);
            end else begin
               // Every accepted non-write cycle is a read; the core has no idle indication.
               rdata_d  = mem_q[acc_idx];
               rd_cnt_d = sat_inc(rd_cnt_q);
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_idx_d = IDX_ZERO;
         end
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   // Control state and registered outputs with synchronous reset into the clear sequence.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= IDX_ZERO;
         rdata_q   <= 32'h0000_0000;
         busy_q    <= 1'b1;
         err_q     <= 1'b0;
         wr_cnt_q  <= CNT_ZERO;
         rd_cnt_q  <= CNT_ZERO;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   // Storage array; contents are defined only once the clear sequence has completed.
   always_ff @(posedge clk_in) begin
      if (mem_we && !rst_in) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

   assign dmrdata_out = rdata_q;
   assign busy_out    = busy_q;
   assign err_out     = err_q;
   assign wr_cnt_out  = wr_cnt_q;
   assign rd_cnt_out  = rd_cnt_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Self-checking bench for riscv_dmem_responder: directed cases plus randomized traffic
// compared every cycle against a behavioural memory model.
module tb_riscv_dmem_responder;
   localparam int DEPTH = 64;
   localparam int IDX_W = 6;
   localparam int CNT_W = 6;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic [3:0]       mask;
   logic             wr;
   logic [31:0]      dmrdata_out;
   logic             busy_out;
   logic             err_out;
   logic [CNT_W-1:0] wr_cnt_out;
   logic [CNT_W-1:0] rd_cnt_out;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_mem [DEPTH];
   int          m_clear_left = 0;
   logic [31:0] m_rdata = 32'h0;
   logic        m_err = 1'b0;
   int          m_wr = 0;
   int          m_rd = 0;

   always #5 clk = ~clk;

   riscv_dmem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .dmaddr_in    (addr),
      .dmwdata_in   (wdata),
      .dmwr_mask_in (mask),
      .dmwr_req_in  (wr),
      .dmrdata_out  (dmrdata_out),
      .busy_out     (busy_out),
      .err_out      (err_out),
      .wr_cnt_out   (wr_cnt_out),
      .rd_cnt_out   (rd_cnt_out)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_reject(input logic [31:0] a, input logic [3:0] m, input logic w);
      bit r;
      int lo, hi, cnt;
      r = (a >= DEPTH * 4);
      lo = -1; hi = -1; cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (m[k]) begin
            if (lo < 0) lo = k;
            hi = k;
            cnt++;
         end
      end
`ifdef DMEM_ALIGN_CHECK_EN
      if (w) begin
         if (cnt != 0 && (lo != int'(a % 4) || cnt != hi - lo + 1)) r = 1'b1;
      end else if (a % 4 != 0) begin
         r = 1'b1;
      end
`endif
      return r;
   endfunction

   task automatic model_step();
      int idx;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
         m_clear_left = DEPTH;
         m_rdata = 32'h0; m_err = 1'b0; m_wr = 0; m_rd = 0;
      end else if (m_clear_left > 0) begin
         m_clear_left--;
         m_rdata = 32'h0; m_err = 1'b0;
      end else if (model_reject(addr, mask, wr)) begin
         m_rdata = 32'h0; m_err = 1'b1;
      end else begin
         idx = int'((addr / 4) % DEPTH);
         m_err = 1'b0;
         if (wr) begin
            for (int k = 0; k < 4; k++)
               if (mask[k]) m_mem[idx][8*k +: 8] = wdata[8*k +: 8];
            m_rdata = 32'h0;
            if (m_wr < CMAX) m_wr++;
         end else begin
            m_rdata = m_mem[idx];
            if (m_rd < CMAX) m_rd++;
         end
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      rst = r; wr = w; addr = a; wdata = d; mask = m;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_clear(input string name);
      int n;
      n = 0;
      while (busy_out === 1'b1 && n < 200) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         n++;
      end
      cmp(name, 32'(n), 32'd64);
   endtask

   // Every-cycle comparison of the DUT against the behavioural model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("rdata",  dmrdata_out, m_rdata);
         cmp("busy",   32'(busy_out), 32'(m_clear_left != 0));
         cmp("err",    32'(err_out), 32'(m_err));
         cmp("wr_cnt", 32'(wr_cnt_out), 32'(m_wr));
         cmp("rd_cnt", 32'(rd_cnt_out), 32'(m_rd));
      end
   end

   initial begin
      rst = 1'b1; wr = 1'b0; addr = 32'h0; wdata = 32'h0; mask = 4'h0;
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      chk_en = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      cmp("reset_busy",   32'(busy_out), 32'd1);
      cmp("reset_rdata",  dmrdata_out, 32'h0);
      cmp("reset_err",    32'(err_out), 32'd0);
      cmp("reset_wr_cnt", 32'(wr_cnt_out), 32'd0);
      cmp("reset_rd_cnt", 32'(rd_cnt_out), 32'd0);
      wait_clear("clear_len_first");

      drive(1'b0, 1'b0, 32'h3C, 32'h0, 4'h0);
      cmp("read_after_clear", dmrdata_out, 32'h0);

      drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      cmp("write_rdata_zero", dmrdata_out, 32'h0);
      drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      cmp("full_write", dmrdata_out, 32'hDEADBEEF);
      cmp("wr_cnt_1", 32'(wr_cnt_out), 32'd1);

      drive(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
      drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      cmp("byte_write", dmrdata_out, 32'hDEADBEAA);
      drive(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
      cmp("mask0_no_err", 32'(err_out), 32'd0);
      drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      cmp("mask0_write", dmrdata_out, 32'hDEADBEAA);
      cmp("wr_cnt_3", 32'(wr_cnt_out), 32'd3);
      cmp("rd_cnt_4", 32'(rd_cnt_out), 32'd4);

      drive(1'b0, 1'b1, 32'h100, 32'h12345678, 4'hF);
      cmp("oob_err",    32'(err_out), 32'd1);
      cmp("oob_rdata",  dmrdata_out, 32'h0);
      cmp("oob_wr_cnt", 32'(wr_cnt_out), 32'd3);
      cmp("oob_rd_cnt", 32'(rd_cnt_out), 32'd4);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cmp("oob_err_pulse",  32'(err_out), 32'd0);
      cmp("oob_alias_word", dmrdata_out, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
      drive(1'b0, 1'b1, 32'h12, 32'h11223344, 4'hF);
      cmp("align_reject_err", 32'(err_out), 32'd1);
      drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      cmp("align_reject_word", dmrdata_out, 32'hDEADBEAA);
      drive(1'b0, 1'b1, 32'h12, 32'h55660000, 4'b1100);
      cmp("align_accept_err", 32'(err_out), 32'd0);
      drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      cmp("align_accept_word", dmrdata_out, 32'h5566BEAA);
`else
      drive(1'b0, 1'b1, 32'h12, 32'h01020304, 4'hF);
      cmp("lsb_write_err", 32'(err_out), 32'd0);
      drive(1'b0, 1'b0, 32'h13, 32'h0, 4'h0);
      cmp("lsb_ignored", dmrdata_out, 32'h01020304);
`endif

      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (30) drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      cmp("busy_mid_clear", 32'(busy_out), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_clear("clear_len_restart");
      drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      cmp("restart_clears_word", dmrdata_out, 32'h0);

      repeat (70) drive(1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
      cmp("rd_cnt_saturates", 32'(rd_cnt_out), 32'd63);
      repeat (70) drive(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
      cmp("wr_cnt_saturates", 32'(wr_cnt_out), 32'd63);

      for (int i = 0; i < 3000; i++) begin
         logic        r_r;
         logic        r_w;
         logic [31:0] r_a;
         logic [3:0]  r_m;
         r_r = ($urandom_range(0, 299) == 0);
         r_w = 1'($urandom_range(0, 1));
         r_m = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0:       r_a = $urandom;
            1:       r_a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1023));
            2, 3, 4: r_a = 32'($urandom_range(0, 31));
            default: r_a = 32'($urandom_range(0, DEPTH * 4 - 1));
         endcase
         drive(r_r, r_w, r_a, $urandom, r_m);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
